matrix_elementwise_unit: RTL and testbench
==========================================

Name: matrix_elementwise_unit

Overview:
Parametrised element-wise matrix arithmetic engine for the NPU datapath. It computes C = A op B over a ROWS x COLS tile, where op is add, subtract or absolute difference, with optional clamping. Operands are captured on start and processed LANES elements per cycle in row-major order. A start/busy/done handshake is provided, plus a synchronous abort.

Parameters:
ROWS, 4, tile rows (>=1)
COLS, 4, tile columns (>=1)
DATA_W, 8, operand element width, unsigned
LANES, 1, elements processed per cycle; must divide ROWS*COLS (elaboration error otherwise)
RES_W, DATA_W+1, result element width, two's complement (fixed at DATA_W+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only in IDLE
abort  in  1  synchronous cancel of a running operation
op  in  2  00 ADD, 01 SUB, 10 ABSDIFF, 11 reserved (treated as ADD)
sat_en  in  1  clamp results to [0, 2^DATA_W-1]
a_flat  in  ROWS*COLS*DATA_W  operand A, element (r,c) at bits [(r*COLS+c)*DATA_W +: DATA_W]
b_flat  in  ROWS*COLS*DATA_W  operand B, same packing
c_flat  out  ROWS*COLS*RES_W  result C, element (r,c) at [(r*COLS+c)*RES_W +: RES_W]
busy  out  1  high from start acceptance until done/abort
done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: c_flat=0, busy=0, done=0, state=IDLE, element index=0, captured operands/op/sat_en=0.
- FSM states: IDLE, RUN. DONE is not a separate state; done is a registered pulse.
- IDLE + start=1 at edge t0: capture a_flat, b_flat, op and sat_en; index<=0; busy<=1; go to RUN. Later input changes are ignored.
- RUN, each edge: write elements index..index+LANES-1 of c_flat from the captured operands; index += LANES.
- K = ROWS*COLS/LANES beats, at edges t1..tK.
- At tK: final write, busy<=0, done<=1 for one cycle, return to IDLE. Latency from start acceptance to done visible is K cycles.
- start while busy: ignored, not queued.
- start in the same cycle done is high: accepted, because the FSM is already in IDLE.
- Arithmetic, with operands zero-extended to RES_W:
  - ADD = a+b, range 0..2^(DATA_W+1)-2.
  - SUB = a-b, two's complement, range -(2^DATA_W-1)..2^DATA_W-1.
  - ABSDIFF = |a-b|.
- sat_en=1: negative results -> 0; results > 2^DATA_W-1 -> 2^DATA_W-1. The result stays in RES_W with MSB 0.
- c_flat is not cleared at start. Unwritten elements keep previous values until their beat; after done all elements hold the new results.
- abort=1 in RUN: at that edge no element is written, busy<=0, done stays 0, index<=0, go to IDLE. Already-written elements are retained. abort in IDLE has no effect. abort has priority over start.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).
- c_flat, busy and done are all registered; there are no combinational input-to-output paths.

Test Plan:
- Defaults, op=SUB, sat_en=0, A all 10, B all 3 -> done pulse exactly 16 cycles after start acceptance; every element = 7; busy high for 16 cycles.
- op=SUB, A(0,0)=0, B(0,0)=255, rest 0 -> element 0 = 9'h101 (-255); same with sat_en=1 -> 0.
- op=ADD, A=B=255 all elements -> 510 (9'h1FE); sat_en=1 -> 255. op=ABSDIFF, A=3, B=200 -> 197.
- LANES=4, ROWS=2, COLS=8 -> done 4 cycles after start. Checking c_flat after the 2nd beat: elements 0..7 updated, elements 8..15 still hold the prior run's values.
- start pulsed at cycles 3 and 8 of a run; A changed mid-run -> both extra starts ignored, results use captured A, a single done pulse.
- abort at beat 5 -> busy low the next cycle, no done, elements 0..4 new, elements 5..15 old. A new start next cycle completes normally. rst_n low mid-run -> c_flat=0, busy=0 immediately.

Source files
------------

// File: rtl/matrix_elementwise_unit.sv
// matrix_elementwise_unit: element-wise add/sub/absdiff over a ROWS x COLS tile,
// LANES elements per cycle in row-major order, with optional clamping and abort.
module matrix_elementwise_unit #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int RES_W  = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    op,
  input  logic                          sat_en,
  input  logic [ROWS*COLS*DATA_W-1:0]   a_flat,
  input  logic [ROWS*COLS*DATA_W-1:0]   b_flat,
  output logic [ROWS*COLS*RES_W-1:0]    c_flat,
  output logic                          busy,
  output logic                          done
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N + 1);
  localparam logic [RES_W-1:0] MAX = {1'b0, {DATA_W{1'b1}}};
  if (N % LANES != 0 || RES_W != DATA_W + 1) begin : g_bad_params
    $error("LANES must divide ROWS*COLS and RES_W must equal DATA_W+1");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N*DATA_W-1:0] a_q, b_q;
  logic [1:0]          op_q;
  logic                sat_q;
  logic [IW-1:0]       idx;
  logic                last, go;
  logic [RES_W-1:0]    res [LANES];
  // Arithmetic is done one bit wider than RES_W so the sign is visible for clamping.
  function automatic logic [RES_W-1:0] calc(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                            input logic [1:0] o, input logic s);
    logic [RES_W:0] sum, dif, r;
    sum = {2'b0, a} + {2'b0, b};
    dif = {2'b0, a} - {2'b0, b};
    r   = (o == 2'b01) ? dif : (o == 2'b10) ? (dif[RES_W] ? -dif : dif) : sum;
    return !s ? r[RES_W-1:0] : r[RES_W] ? '0 : (r[RES_W-1:0] > MAX) ? MAX : r[RES_W-1:0];
  endfunction
  assign last = idx == IW'(N - LANES);
  assign go   = start && !abort;
  always_comb begin
    for (int l = 0; l < LANES; l++)
      res[l] = calc(a_q[(int'(idx) + l)*DATA_W +: DATA_W], b_q[(int'(idx) + l)*DATA_W +: DATA_W],
                    op_q, sat_q);
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (go ? RUN : IDLE) : ((abort || last) ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      sat_q  <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      c_flat <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          a_q   <= a_flat;
          b_q   <= b_flat;
          op_q  <= op;
          sat_q <= sat_en;
          idx   <= '0;
          busy  <= 1'b1;
        end
      end else if (abort) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        for (int l = 0; l < LANES; l++)
          c_flat[(int'(idx) + l)*RES_W +: RES_W] <= res[l];
        idx  <= last ? '0 : idx + IW'(LANES);
        busy <= !last;
        done <= last;
      end
    end
endmodule

// File: tb/tb_matrix_elementwise_unit.sv
// tb_matrix_elementwise_unit: directed vector table plus multi-cycle corner sequences
// on a single-lane 4x4 instance and a 4-lane 2x8 instance.
module tb_matrix_elementwise_unit;
  localparam int N = 16, DW = 8, RW = 9;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0, abort = 0, sat_en = 0;
  logic [1:0] op = 0;
  logic [N*DW-1:0] a_flat = '0, b_flat = '0;
  logic [N*RW-1:0] c0, c1;
  logic busy0, busy1, done0, done1;
  int checks = 0, errors = 0;
  matrix_elementwise_unit dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .op(op), .sat_en(sat_en),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c0), .busy(busy0), .done(done0));
  matrix_elementwise_unit #(.ROWS(2), .COLS(8), .LANES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .op(op), .sat_en(sat_en),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c1), .busy(busy1), .done(done1));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]    op;
    logic          sat;
    logic [DW-1:0] a, b;
    logic [RW-1:0] exp;
  } vec_t;
  vec_t vt [9];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask
  function automatic int nbad(input logic [N*RW-1:0] c, input int lo, input int hi, input logic [RW-1:0] e);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (c[i*RW +: RW] !== e) n++;
    return n;
  endfunction
  task automatic elems(input string name, input int sel, input int lo, input int hi, input logic [RW-1:0] e);
    chk(name, nbad(sel != 0 ? c1 : c0, lo, hi, e), 0);
  endtask
  task automatic setup(input logic [1:0] o, input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op = o;
    sat_en = s;
    a_flat = {N{a}};
    b_flat = {N{b}};
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input int sel);
    if (sel != 0) start1 = 1; else start0 = 1;
    tick();
    start0 = 0;
    start1 = 0;
  endtask
  task automatic wait_done(input int sel, output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (!(sel != 0 ? done1 : done0) && lat < 200) begin
      if (sel != 0 ? busy1 : busy0) bc++;
      tick();
      lat++;
    end
  endtask
  initial begin
    int lat, bc, dn, at;
    vt[0] = '{2'b01, 1'b0, 8'd10,  8'd3,   9'd7};
    vt[1] = '{2'b01, 1'b0, 8'd0,   8'd255, 9'h101};
    vt[2] = '{2'b01, 1'b1, 8'd0,   8'd255, 9'd0};
    vt[3] = '{2'b00, 1'b0, 8'd255, 8'd255, 9'h1FE};
    vt[4] = '{2'b00, 1'b1, 8'd255, 8'd255, 9'd255};
    vt[5] = '{2'b10, 1'b0, 8'd3,   8'd200, 9'd197};
    vt[6] = '{2'b10, 1'b0, 8'd200, 8'd3,   9'd197};
    vt[7] = '{2'b11, 1'b0, 8'd5,   8'd6,   9'd11};
    vt[8] = '{2'b01, 1'b0, 8'd3,   8'd200, 9'h13B};
    repeat (2) tick();
    elems("reset_c0", 0, 0, 15, '0);
    elems("reset_c1", 1, 0, 15, '0);
    chk("reset_busy", int'(busy0) + int'(busy1), 0);
    chk("reset_done", int'(done0) + int'(done1), 0);
    rst_n = 1;
    tick();
    foreach (vt[i]) begin
      setup(vt[i].op, vt[i].sat, vt[i].a, vt[i].b);
      kick(0);
      chk($sformatf("v%0d_busy", i), int'(busy0), 1);
      wait_done(0, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, 16);
      chk($sformatf("v%0d_busy_cycles", i), bc, 16);
      elems($sformatf("v%0d_elems", i), 0, 0, 15, vt[i].exp);
      tick();
      chk($sformatf("v%0d_done_pulse", i), int'(done0), 0);
    end
    setup(2'b00, 1'b0, 8'd1, 8'd1);
    kick(1);
    wait_done(1, lat, bc);
    chk("l4_latency", lat, 4);
    elems("l4_first", 1, 0, 15, 9'd2);
    setup(2'b01, 1'b0, 8'd10, 8'd3);
    kick(1);
    repeat (2) tick();
    elems("l4_beat2_new", 1, 0, 7, 9'd7);
    elems("l4_beat2_old", 1, 8, 15, 9'd2);
    wait_done(1, lat, bc);
    chk("l4_rest_latency", lat, 2);
    elems("l4_final", 1, 0, 15, 9'd7);
    setup(2'b01, 1'b0, 8'd20, 8'd5);
    kick(0);
    dn = 0;
    at = 0;
    for (int k = 1; k <= 24; k++) begin
      start0 = (k == 3 || k == 8);
      if (k == 3) a_flat = {N{8'd100}};
      tick();
      if (done0) begin
        dn++;
        at = k;
      end
    end
    start0 = 0;
    chk("ignore_start_done_count", dn, 1);
    chk("ignore_start_done_at", at, 16);
    chk("ignore_start_idle", int'(busy0), 0);
    elems("ignore_start_elems", 0, 0, 15, 9'd15);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_idle_busy", int'(busy0), 0);
    elems("abort_idle_elems", 0, 0, 15, 9'd15);
    setup(2'b00, 1'b0, 8'd1, 8'd2);
    kick(0);
    repeat (5) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    elems("abort_new", 0, 0, 4, 9'd3);
    elems("abort_old", 0, 5, 15, 9'd15);
    setup(2'b01, 1'b0, 8'd10, 8'd3);
    kick(0);
    wait_done(0, lat, bc);
    chk("after_abort_latency", lat, 16);
    elems("after_abort_elems", 0, 0, 15, 9'd7);
    setup(2'b00, 1'b0, 8'd4, 8'd4);
    kick(0);
    chk("start_on_done_busy", int'(busy0), 1);
    wait_done(0, lat, bc);
    chk("start_on_done_latency", lat, 16);
    elems("start_on_done_elems", 0, 0, 15, 9'd8);
    setup(2'b00, 1'b0, 8'd9, 8'd9);
    kick(0);
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    elems("async_reset_c0", 0, 0, 15, '0);
    elems("async_reset_c1", 1, 0, 15, '0);
    chk("async_reset_busy", int'(busy0), 0);
    tick();
    rst_n = 1;
    tick();
    chk("post_reset_busy", int'(busy0), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
